// File: rtl/dc_wr_fifo.sv
// Store write-back buffer between write-back and the dcache. Stores drain in order from the head.
// Loads whose 16-byte line span overlaps a buffered or incoming store raise mem_conflict.
module dc_wr_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_push,
  input  logic [31:0]              wb_wr_addr,
  input  logic [63:0]              wb_wr_data,
  input  logic [1:0]               wb_wr_size,
  input  logic                     mem_wr_done,
  input  logic                     v_mem_read,
  input  logic [31:0]              mem_rd_addr,
  input  logic [1:0]               mem_rd_size,
  output logic [31:0]              mem_wr_addr,
  output logic [63:0]              mem_wr_data,
  output logic [1:0]               mem_wr_size,
  output logic                     wr_fifo_empty,
  output logic                     wr_fifo_to_be_full,
  output logic                     wr_fifo_full,
  output logic [$clog2(DEPTH):0]   wr_fifo_count,
  output logic                     mem_conflict,
  output logic                     push_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULLC = (AW+1)'(DEPTH);

  logic [AW-1:0] head_q, head_d, tail_q, tail_d, off;
  logic [AW:0]   count_q, count_d;
  logic          push_drop_q, push_drop_d;
  logic [31:0]   addr_q [DEPTH];
  logic [63:0]   data_q [DEPTH];
  logic [1:0]    size_q [DEPTH];
  logic          pop, push_ok, conf;
  logic [27:0]   ld_s, ld_e;

  function automatic logic [27:0] line_end(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] e;
    e = a + (32'd1 << s) - 32'd1;
    return e[31:4];
  endfunction

  function automatic logic overlap(input logic [27:0] as, ae, bs, be);
    return (as <= be) && (bs <= ae);
  endfunction

  // A full buffer still takes a push when the head drains in the same cycle.
  assign pop     = mem_wr_done && (count_q != '0);
  assign push_ok = wb_push && ((count_q < FULLC) || pop);

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    push_drop_d = push_drop_q | (wb_push & ~push_ok);
    if (pop)     head_d = head_q + 1'b1;
    if (push_ok) tail_d = tail_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      push_drop_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      push_drop_q <= push_drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[tail_q] <= wb_wr_addr;
      data_q[tail_q] <= wb_wr_data;
      size_q[tail_q] <= wb_wr_size;
    end
  end

  // The popping head still blocks loads this cycle; it leaves the valid window next cycle.
  always_comb begin
    conf = 1'b0;
    off  = '0;
    ld_s = mem_rd_addr[31:4];
    ld_e = line_end(mem_rd_addr, mem_rd_size);
    if (wb_push && overlap(ld_s, ld_e, wb_wr_addr[31:4], line_end(wb_wr_addr, wb_wr_size)))
      conf = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - head_q;
      if (({1'b0, off} < count_q) &&
          overlap(ld_s, ld_e, addr_q[i][31:4], line_end(addr_q[i], size_q[i])))
        conf = 1'b1;
    end
  end

  assign mem_conflict       = v_mem_read & conf;
  assign mem_wr_addr        = (count_q != '0) ? addr_q[head_q] : 32'd0;
  assign mem_wr_data        = (count_q != '0) ? data_q[head_q] : 64'd0;
  assign mem_wr_size        = (count_q != '0) ? size_q[head_q] : 2'd0;
  assign wr_fifo_empty      = (count_q == '0);
  assign wr_fifo_to_be_full = (count_q >= FULLC - 1'b1);
  assign wr_fifo_full       = (count_q == FULLC);
  assign wr_fifo_count      = count_q;
  assign push_drop          = push_drop_q;
endmodule

// File: doc/dc_wr_fifo.md
DC_WR_FIFO -- requirements
Module: dc_wr_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of store entries; legal values 2, 4, 8 only.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port wb_push  in  1  write-back stage presents a committed store this cycle.
REQ-005 SHALL have port wb_wr_addr  in  32  store virtual byte address.
REQ-006 SHALL have port wb_wr_data  in  64  store data, little-endian, LSB-aligned.
REQ-007 SHALL have port wb_wr_size  in  2  size code: 0=1B, 1=2B, 2=4B, 3=8B.
REQ-008 SHALL have port mem_wr_done  in  1  dcache completed the head store; pop request.
REQ-009 SHALL have port v_mem_read  in  1  read-operand stage has a valid load.
REQ-010 SHALL have port mem_rd_addr  in  32  load byte address.
REQ-011 SHALL have port mem_rd_size  in  2  load size code (same encoding as REQ-007).
REQ-012 SHALL have port mem_wr_addr / mem_wr_data / mem_wr_size  out  32/64/2  head entry fields to dcache.
REQ-013 SHALL have port wr_fifo_empty  out  1  no valid entries.
REQ-014 SHALL have port wr_fifo_to_be_full  out  1  count >= DEPTH-1.
REQ-015 SHALL have port wr_fifo_full  out  1  count == DEPTH.
REQ-016 SHALL have port wr_fifo_count  out  log2(DEPTH)+1  current occupancy.
REQ-017 SHALL have port mem_conflict  out  1  pending load overlaps a buffered or incoming store.
REQ-018 SHALL have port push_drop  out  1  sticky flag: a push was discarded.

Function
REQ-019 SHALL operate as an in-order circular buffer: head pointer, tail pointer, occupancy counter, each wrapping modulo DEPTH (pointers) without extra state.
REQ-020 SHALL accept a push when wb_push=1 and (count<DEPTH or mem_wr_done=1 with count>0); entry written at tail, tail advances by 1.
REQ-021 SHALL accept a pop when mem_wr_done=1 and count>0; head advances by 1.
REQ-022 SHALL, on simultaneous accepted push and pop, leave count unchanged; when full, the pushed entry occupies the slot freed by the pop.
REQ-023 SHALL ignore mem_wr_done when count==0 (no pointer or count change).
REQ-024 SHALL, on push while full without pop, discard the store, hold all state, and set push_drop=1 on the next cycle until reset.
REQ-025 SHALL drive mem_wr_addr/data/size combinationally from the head entry when count>0, and all-zero when count==0.
REQ-026 SHALL make a pushed entry visible on mem_wr_* the cycle after the push (no same-cycle bypass).
REQ-027 SHALL derive wr_fifo_empty, wr_fifo_to_be_full, wr_fifo_full, wr_fifo_count from the registered count only (no combinational path from wb_push/mem_wr_done).
REQ-028 SHALL compute each access's line span as start line = addr[31:4] and end line = (addr + bytes(size) - 1)[31:4], 32-bit wrap-around arithmetic.
REQ-029 SHALL assert mem_conflict when v_mem_read=1 and the load line span intersects the span of any valid entry or of the entry being pushed this cycle (wb_push=1).
REQ-030 SHALL exclude the entry being popped this cycle from conflict only after the pop takes effect (next cycle), i.e. the head still counts during its pop cycle.
REQ-031 SHALL drive mem_conflict=0 whenever v_mem_read=0.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, clear head, tail, count, and push_drop; the reset cycle overrides any concurrent push or pop.
REQ-033 SHALL present after reset: wr_fifo_empty=1, wr_fifo_to_be_full=0, wr_fifo_full=0, wr_fifo_count=0, mem_wr_*=0, mem_conflict=0 (entry storage need not be reset).
REQ-034 SHALL discard all buffered stores on reset asserted mid-operation.

Verification
REQ-035 SHALL cover: 4 pushes (addr 0x100,0x110,0x120,0x130) no pops -> count 1,2,3,4; to_be_full at count 3; full at 4; mem_wr_addr=0x100 throughout.
REQ-036 SHALL cover: full FIFO, push 0x140 with mem_wr_done same cycle -> count stays 4, head becomes 0x110, 0x140 drained fourth; push when full with no pop -> push_drop=1, count 4.
REQ-037 SHALL cover: entry addr 0x10E size 3 (spans lines 0x10,0x11); load addr 0x114 size 2 v_mem_read=1 -> mem_conflict=1; load 0x120 -> 0.
REQ-038 SHALL cover: empty FIFO, wb_push addr 0x200 and load addr 0x204 same cycle -> mem_conflict=1 that cycle; mem_wr_addr=0x200 only from the next cycle.
REQ-039 SHALL cover: pointer wrap, 10 push/pop pairs with DEPTH=4 -> data order preserved, count never exceeds 4; mem_wr_done when empty -> no change.
REQ-040 SHALL cover: rst=1 with 3 entries and concurrent push -> next cycle count=0, empty=1, mem_wr_*=0, push_drop=0.
